switch_char_stepper: RTL
========================

Name: switch_char_stepper

Overview:
- Upstream stage for the character-select seven-segment decoder.
- Debounces a raw board push-switch and steps an 8-bit ASCII character code through a configurable alphanumeric range.
- One step per press; auto-repeat while the switch is held.
- o_Char drives the decoder's character-select input directly. o_Char_Strobe marks each change for any logging/consumer logic.

Parameters:
- DEBOUNCE_LIMIT, 250000: consecutive stable cycles before the debounced level changes (10 ms at 25 MHz).
- HOLD_CYCLES, 12500000: cycles the switch must stay held after the first step before auto-repeat starts (0.5 s).
- REPEAT_CYCLES, 5000000: cycles between auto-repeat steps (0.2 s).
- CHAR_FIRST, 8'h30: lowest code in the range ("0").
- CHAR_LAST, 8'h5A: highest code in the range ("Z").

Ports:
- i_Clk  in  1  system clock
- i_Reset  in  1  synchronous, active-high reset
- i_Switch  in  1  raw, asynchronous, bouncing push-switch (1 = pressed)
- i_Dir  in  1  step direction: 0 = increment, 1 = decrement
- o_Char  out  8  current ASCII code, to the character-select decoder
- o_Char_Strobe  out  1  single-cycle pulse in the cycle after o_Char changes
- o_Switch_Debounced  out  1  debounced switch level

Behaviour:
- Reset (i_Reset high at a rising edge of i_Clk):
  - o_Char = CHAR_FIRST; o_Char_Strobe = 0; o_Switch_Debounced = 0.
  - Synchronizer flops = 0; FSM = IDLE; all counters = 0.
  - Reset mid-hold or mid-repeat aborts immediately. No strobe is issued in the reset cycle.
- Synchronizer:
  - i_Switch passes through 2 flops before any use.
- Debounce:
  - The counter increments while the synced input differs from o_Switch_Debounced. It clears to 0 when they match.
  - When the count reaches DEBOUNCE_LIMIT-1 while still differing, o_Switch_Debounced toggles and the counter clears.
  - Total latency from a clean i_Switch edge to o_Switch_Debounced: 2 + DEBOUNCE_LIMIT cycles.
  - Any glitch shorter than DEBOUNCE_LIMIT cycles produces no change.
- Step rule (advance):
  - Increment: CHAR_LAST wraps to CHAR_FIRST.
  - Decrement: CHAR_FIRST wraps to CHAR_LAST.
  - Punctuation gap: 8'h39 increments to 8'h41, and 8'h41 decrements to 8'h39. This applies only when CHAR_FIRST <= 8'h39 and CHAR_LAST >= 8'h41. Codes 8'h3A–8'h40 are never output.
  - i_Dir is sampled in the advance cycle only; changing it mid-hold affects only the next step.
  - o_Char updates at the advance clock edge. o_Char_Strobe is high for exactly the following cycle.
- FSM, one timer (width sized for max(HOLD_CYCLES, REPEAT_CYCLES)):
  - IDLE: a rising edge of o_Switch_Debounced triggers an advance, clears the timer, and goes to HOLD.
  - HOLD: the timer increments each cycle.
    - Debounced low: go to IDLE.
    - Timer == HOLD_CYCLES-1: advance, clear the timer, go to REPEAT.
  - REPEAT: the timer increments each cycle.
    - Debounced low: go to IDLE.
    - Timer == REPEAT_CYCLES-1: advance and clear the timer.
  - Release in the same cycle as timer expiry: release wins; no advance, go to IDLE.
- Debounced falling edges never advance.
- Between strobes, o_Char holds its value.

Test Plan (DEBOUNCE_LIMIT=4, HOLD_CYCLES=10, REPEAT_CYCLES=5, defaults otherwise):
- Reset: i_Reset high for 2 cycles with i_Switch=1 -> o_Char=8'h30, strobe 0, debounced 0 throughout; after release, first step occurs 2+4 cycles later.
- Bounce rejection: i_Switch toggles 1/0 with 3-cycle pulses, then held 1 -> exactly one strobe; o_Char 8'h30->8'h31; release before HOLD expiry -> no further step.
- Gap and wrap, i_Dir=0: 10 single presses from 8'h30 -> o_Char=8'h41, never 8'h3A. Preload via presses to 8'h5A, one more press -> 8'h30.
- Decrement: i_Dir=1 from reset, one press -> 8'h5A; from 8'h41 one press -> 8'h39.
- Auto-repeat: hold 40 cycles after debounce -> strobes at debounced-rise+1, +11, +16, +21, ... (1 + 1 + floor((40-10)/5) total); release -> no more strobes.
- Release/expiry collision and mid-hold reset: drop the debounced level exactly at HOLD expiry -> no step, FSM IDLE. Assert i_Reset during REPEAT -> o_Char=8'h30 next cycle, no strobe.

Source files
------------

// File: rtl/switch_char_stepper.sv
// switch_char_stepper: debounced push-switch that steps an ASCII code through a range, with auto-repeat while held.
//   i_Clk              system clock
//   i_Reset            synchronous active-high reset
//   i_Switch           raw bouncing push-switch, 1 = pressed
//   i_Dir              step direction, 0 = increment, 1 = decrement
//   o_Char             current ASCII code for the character-select decoder
//   o_Char_Strobe      one-cycle pulse in the cycle after o_Char changes
//   o_Switch_Debounced debounced switch level
module switch_char_stepper #(
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned HOLD_CYCLES    = 12500000,
  parameter int unsigned REPEAT_CYCLES  = 5000000,
  parameter logic [7:0]  CHAR_FIRST     = 8'h30,
  parameter logic [7:0]  CHAR_LAST      = 8'h5A
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Switch,
  input  logic       i_Dir,
  output logic [7:0] o_Char,
  output logic       o_Char_Strobe,
  output logic       o_Switch_Debounced
);
  localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned DW   = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [DW-1:0] DEB_END  = DW'(DEBOUNCE_LIMIT - 1);
  localparam logic [TW-1:0] HOLD_END = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_END  = TW'(REPEAT_CYCLES - 1);
  // Skip the punctuation block 3A..40 only when the range spans both digits and letters.
  localparam bit GAP = (CHAR_FIRST <= 8'h39) && (CHAR_LAST >= 8'h41);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_e;

  logic [1:0]    sync_q;
  logic          deb_q, deb_d, deb_prev_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          deb_diff, deb_flip;
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    char_q, char_d, step_up, step_dn;
  logic          strobe_q, advance;

  always_comb begin
    deb_diff  = sync_q[1] ^ deb_q;
    deb_flip  = deb_diff && (deb_cnt_q == DEB_END);
    deb_cnt_d = (deb_diff && !deb_flip) ? deb_cnt_q + 1'b1 : '0;
    deb_d     = deb_q ^ deb_flip;
  end

  // Release is tested before timer expiry so a release in the expiry cycle never steps.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    advance = 1'b0;
    if (state_q == IDLE) begin
      timer_d = '0;
      if (deb_q && !deb_prev_q) begin
        advance = 1'b1;
        state_d = HOLD;
      end
    end else if (!deb_q) begin
      state_d = IDLE;
      timer_d = '0;
    end else if (state_q == HOLD && timer_q == HOLD_END) begin
      advance = 1'b1;
      timer_d = '0;
      state_d = REPEAT;
    end else if (state_q == REPEAT && timer_q == REP_END) begin
      advance = 1'b1;
      timer_d = '0;
    end
  end

  always_comb begin
    step_up = (char_q == CHAR_LAST) ? CHAR_FIRST : (GAP && char_q == 8'h39) ? 8'h41 : char_q + 8'd1;
    step_dn = (char_q == CHAR_FIRST) ? CHAR_LAST : (GAP && char_q == 8'h41) ? 8'h39 : char_q - 8'd1;
    char_d  = advance ? (i_Dir ? step_dn : step_up) : char_q;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync_q     <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
      state_q    <= IDLE;
      timer_q    <= '0;
      char_q     <= CHAR_FIRST;
      strobe_q   <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], i_Switch};
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      char_q     <= char_d;
      strobe_q   <= advance;
    end
  end

  assign o_Char             = char_q;
  assign o_Char_Strobe      = strobe_q;
  assign o_Switch_Debounced = deb_q;
endmodule
